// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared sizes and types for the physical-register free list
package free_list_pkg;
    localparam int WAYS      = 4;
    localparam int PRF       = 64;
    localparam int ARCH_REGS = 32;
    localparam int DEPTH     = PRF - ARCH_REGS;
    localparam int TAG_W     = $clog2(PRF);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int PTR_W     = IDX_W + 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int WCNT_W    = $clog2(WAYS + 1);

    typedef logic [TAG_W-1:0] preg_tag_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;
endpackage

// File: rtl/free_list_popcount_prefix.sv
// rtl/free_list_popcount_prefix.sv - exclusive prefix popcounts of a mask plus its total
module popcount_prefix #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]         mask,
    output logic [W-1:0][CW-1:0] prefix,
    output logic [CW-1:0]        total
);
    logic [CW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(mask[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular FIFO of free PRF tags with single-cycle exception rollback
module free_list
    import free_list_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        except,
    input  logic [WAYS-1:0]             alloc_req,
    output logic [WAYS-1:0][TAG_W-1:0]  alloc_idx,
    output logic                        alloc_stall,
    input  logic [WAYS-1:0]             retire_en,
    input  logic [WAYS-1:0][TAG_W-1:0]  retire_old_idx,
    output logic [CNT_W-1:0]            free_count,
    output logic [PTR_W-1:0]            head_out,
    output logic [PTR_W-1:0]            tail_out,
    output logic [PTR_W-1:0]            retire_head_out
);
    preg_tag_t fifo_q [DEPTH];
    preg_tag_t fifo_d [DEPTH];
    fl_ptr_t   head_q, head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_ptr_t   rhead_q, rhead_d;

    logic [WAYS-1:0][WCNT_W-1:0] a_pre, r_pre;
    logic [WCNT_W-1:0]           a_tot, r_tot;

    popcount_prefix #(.W(WAYS), .CW(WCNT_W)) u_alloc_pc (
        .mask   (alloc_req),
        .prefix (a_pre),
        .total  (a_tot)
    );

    popcount_prefix #(.W(WAYS), .CW(WCNT_W)) u_retire_pc (
        .mask   (retire_en),
        .prefix (r_pre),
        .total  (r_tot)
    );

    // Wrap bit makes the truncated difference distinguish full (DEPTH) from empty (0).
    assign free_count      = CNT_W'(tail_q - head_q);
    assign alloc_stall     = CNT_W'(a_tot) > free_count;
    assign head_out        = head_q;
    assign tail_out        = tail_q;
    assign retire_head_out = rhead_q;

    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            alloc_idx[i] = fifo_q[head_q[IDX_W-1:0] + IDX_W'(a_pre[i])];
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        for (int j = 0; j < WAYS; j++) begin
            if (retire_en[j]) begin
                fifo_d[tail_q[IDX_W-1:0] + IDX_W'(r_pre[j])] = retire_old_idx[j];
            end
        end
        tail_d  = tail_q + PTR_W'(r_tot);
        rhead_d = rhead_q + PTR_W'(r_tot);
        // Rollback discards every allocation past the last retired one, including this cycle's.
        if (except) begin
            head_d = rhead_d;
        end else if (!alloc_stall) begin
            head_d = head_q + PTR_W'(a_tot);
        end else begin
            head_d = head_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= TAG_W'(ARCH_REGS + i);
            end
            head_q  <= '0;
            rhead_q <= '0;
            tail_q  <= PTR_W'(DEPTH);
        end else begin
            fifo_q  <= fifo_d;
            head_q  <= head_d;
            rhead_q <= rhead_d;
            tail_q  <= tail_d;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        ((CNT_W + 1)'(free_count) + (CNT_W + 1)'(r_tot)) <= (CNT_W + 1)'(DEPTH));
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed vector table plus randomized queue-model check of free_list
module tb_free_list;
    logic             clock;
    logic             reset_n;
    logic             except;
    logic [3:0]       alloc_req;
    logic [3:0][5:0]  alloc_idx;
    logic             alloc_stall;
    logic [3:0]       retire_en;
    logic [3:0][5:0]  retire_old_idx;
    logic [5:0]       free_count;
    logic [5:0]       head_out;
    logic [5:0]       tail_out;
    logic [5:0]       retire_head_out;

    free_list dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .except          (except),
        .alloc_req       (alloc_req),
        .alloc_idx       (alloc_idx),
        .alloc_stall     (alloc_stall),
        .retire_en       (retire_en),
        .retire_old_idx  (retire_old_idx),
        .free_count      (free_count),
        .head_out        (head_out),
        .tail_out        (tail_out),
        .retire_head_out (retire_head_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit              rst;
        logic [3:0]      areq;
        logic [3:0]      ren;
        logic [3:0][5:0] old;
        bit              exc;
        bit              chk_stall;
        bit              exp_stall;
        logic [3:0][5:0] exp_idx;
        int              exp_free;
        int              exp_head;
        int              exp_tail;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, logic [3:0] areq, logic [3:0] ren, logic [23:0] old,
                                bit exc, bit cs, bit st, logic [23:0] idx,
                                int fr, int hd, int tl);
        vec_t v;
        v.rst = rst; v.areq = areq; v.ren = ren; v.old = old; v.exc = exc;
        v.chk_stall = cs; v.exp_stall = st; v.exp_idx = idx;
        v.exp_free = fr; v.exp_head = hd; v.exp_tail = tl;
        return v;
    endfunction

    function automatic logic [23:0] seq4(int base);
        return {6'(base + 3), 6'(base + 2), 6'(base + 1), 6'(base)};
    endfunction

    // Reference model: ordered free tags, plus allocations not yet consumed by retirement.
    int free_q[$];
    int spec_q[$];
    int head_m, tail_m, rh_m;

    task automatic model_reset();
        free_q.delete();
        spec_q.delete();
        for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
        head_m = 0; tail_m = 32; rh_m = 0;
    endtask

    task automatic drive_idle();
        reset_n = 1'b1; except = 1'b0; alloc_req = '0; retire_en = '0; retire_old_idx = '0;
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;

        // Directed scenarios
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 24'd0, 0, 0, 0, 24'd0, 32, 0, 32));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 24'd0, 0, 1, 0, seq4(32), 28, 4, 32));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 24'd0, 0, 0, 0, 24'd0, 32, 0, 32));
        tbl.push_back(mk(0, 4'b0101, 4'b0000, 24'd0, 0, 1, 0, {6'd0, 6'd33, 6'd0, 6'd32}, 30, 2, 32));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 24'd0, 0, 0, 0, 24'd0, 32, 0, 32));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 4'b1111, 4'b0000, 24'd0, 0, 1, 0, seq4(32 + 4 * k), 28 - 4 * k, (4 * k + 4) % 64, 32));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 24'd0, 0, 1, 1, 24'd0, 0, 32, 32));
        tbl.push_back(mk(0, 4'b0000, 4'b1010, {6'd7, 6'd0, 6'd5, 6'd0}, 0, 1, 0, 24'd0, 2, 32, 34));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 24'd0, 0, 1, 0, {6'd0, 6'd0, 6'd7, 6'd5}, 0, 34, 34));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 24'd0, 0, 0, 0, 24'd0, 32, 0, 32));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 24'd0, 0, 1, 0, seq4(32), 28, 4, 32));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 24'd0, 0, 1, 0, {6'd0, 6'd0, 6'd37, 6'd36}, 26, 6, 32));
        tbl.push_back(mk(0, 4'b0000, 4'b0011, {6'd0, 6'd0, 6'd4, 6'd3}, 1, 1, 0, 24'd0, 32, 2, 34));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 24'd0, 0, 1, 0, seq4(34), 28, 6, 34));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 24'd0, 0, 0, 0, 24'd0, 32, 0, 32));
        for (int k = 0; k < 7; k++)
            tbl.push_back(mk(0, 4'b1111, 4'b0000, 24'd0, 0, 1, 0, seq4(32 + 4 * k), 28 - 4 * k, 4 * k + 4, 32));
        tbl.push_back(mk(0, 4'b0011, 4'b0000, 24'd0, 0, 1, 0, {6'd0, 6'd0, 6'd61, 6'd60}, 2, 30, 32));
        tbl.push_back(mk(0, 4'b0000, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd10}, 0, 1, 0, 24'd0, 3, 30, 33));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 24'd0, 0, 1, 1, 24'd0, 3, 30, 33));
        tbl.push_back(mk(0, 4'b0111, 4'b0000, 24'd0, 0, 1, 0, {6'd0, 6'd10, 6'd63, 6'd62}, 0, 33, 33));
        tbl.push_back(mk(1, 4'b1111, 4'b0011, {6'd0, 6'd0, 6'd9, 6'd8}, 0, 0, 0, 24'd0, 32, 0, 32));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 24'd0, 0, 1, 0, {6'd0, 6'd0, 6'd0, 6'd32}, 31, 1, 32));

        @(posedge clock); #1;
        for (int v = 0; v < tbl.size(); v++) begin
            reset_n = !tbl[v].rst; except = tbl[v].exc; alloc_req = tbl[v].areq;
            retire_en = tbl[v].ren; retire_old_idx = tbl[v].old;
            @(negedge clock);
            if (tbl[v].chk_stall) begin
                chk($sformatf("v%0d_stall", v), int'(alloc_stall), int'(tbl[v].exp_stall));
                if (!tbl[v].exp_stall)
                    for (int i = 0; i < 4; i++)
                        if (tbl[v].areq[i])
                            chk($sformatf("v%0d_idx%0d", v, i), int'(alloc_idx[i]), int'(tbl[v].exp_idx[i]));
            end
            @(posedge clock); #1;
            chk($sformatf("v%0d_free", v), int'(free_count), tbl[v].exp_free);
            chk($sformatf("v%0d_head", v), int'(head_out), tbl[v].exp_head);
            chk($sformatf("v%0d_tail", v), int'(tail_out), tbl[v].exp_tail);
            if (v == 0) chk("reset_rhead", int'(retire_head_out), 0);
        end

        // Randomized run against the queue model
        drive_idle();
        reset_n = 1'b0;
        @(posedge clock); #1;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            int maxr, n, k, nret;
            bit st, exc;
            logic [3:0] ar, rr;
            logic [3:0][5:0] old;
            ar  = 4'($urandom);
            rr  = 4'($urandom);
            exc = ($urandom_range(0, 11) == 0);
            maxr = 32 - free_q.size();
            if (spec_q.size() < maxr) maxr = spec_q.size();
            if (maxr > 4) maxr = 4;
            for (int j = 3; j >= 0; j--)
                if ($countones(rr) > maxr && rr[j]) rr[j] = 1'b0;
            for (int j = 0; j < 4; j++) old[j] = 6'($urandom_range(0, 63));
            reset_n = 1'b1; except = exc; alloc_req = ar; retire_en = rr; retire_old_idx = old;
            @(negedge clock);
            n  = $countones(ar);
            st = (n > free_q.size());
            chk($sformatf("r%0d_stall", c), int'(alloc_stall), int'(st));
            k = 0;
            for (int i = 0; i < 4; i++)
                if (ar[i]) begin
                    if (!st) chk($sformatf("r%0d_idx%0d", c, i), int'(alloc_idx[i]), free_q[k]);
                    k++;
                end
            nret = $countones(rr);
            for (int j = 0; j < nret; j++) void'(spec_q.pop_front());
            if (!exc && !st)
                for (int j = 0; j < n; j++) spec_q.push_back(free_q.pop_front());
            for (int j = 0; j < 4; j++) if (rr[j]) free_q.push_back(int'(old[j]));
            tail_m = (tail_m + nret) % 64;
            rh_m   = (rh_m + nret) % 64;
            if (exc) begin
                free_q = {spec_q, free_q};
                spec_q.delete();
                head_m = rh_m;
            end else if (!st) begin
                head_m = (head_m + n) % 64;
            end
            @(posedge clock); #1;
            chk($sformatf("r%0d_free", c), int'(free_count), free_q.size());
            chk($sformatf("r%0d_head", c), int'(head_out), head_m);
            chk($sformatf("r%0d_tail", c), int'(tail_out), tail_m);
            chk($sformatf("r%0d_rhead", c), int'(retire_head_out), rh_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
